// File: rtl/vs1003_responder_pkg.sv
// Shared constants and SCI state encoding for the VS1003B bus responder.
package vs_pkg;

  localparam logic [7:0]  OP_WRITE   = 8'h02;
  localparam logic [7:0]  OP_READ    = 8'h03;
  localparam logic [3:0]  ADDR_MODE  = 4'h0;
  localparam logic [3:0]  ADDR_VOL   = 4'hB;
  localparam logic [15:0] MODE_RESET = 16'h0800;
  localparam int          SM_RESET   = 2;

  typedef enum logic [2:0] {
    SCI_IDLE,
    SCI_OPCODE,
    SCI_ADDR,
    SCI_DATA,
    SCI_IGNORE
  } sci_state_t;

  function automatic logic [15:0] reg_reset_val(input logic [3:0] a);
    return (a == ADDR_MODE) ? MODE_RESET : 16'h0000;
  endfunction

endpackage

// File: rtl/vs1003_responder_sync_fifo.sv
// Byte FIFO with show-ahead head output, occupancy count and synchronous flush.
module sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push_ok && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vs1003_responder.sv
// Slave end of the VS1003B SCI/SDI link: oversampled serial decode, register file,
// SDI byte FIFO and DREQ back-pressure.
//
// state      | meaning
// SCI_IDLE   | XCS high, waiting for a frame
// SCI_OPCODE | shifting in the 8-bit opcode
// SCI_ADDR   | shifting in the 8-bit address
// SCI_DATA   | shifting write data in / read data out on SO
// SCI_IGNORE | frame done or unsupported, wait for XCS high
module vs1003_responder
  import vs_pkg::*;
#(
  parameter int FIFO_DEPTH   = 32,
  parameter int DREQ_SPACE   = 4,
  parameter int SCI_BUSY     = 64,
  parameter int RESET_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        XCS,
  input  logic        XDCS,
  input  logic        SCLK,
  input  logic        SI,
  output logic        SO,
  output logic        DREQ,
  output logic [15:0] vol,
  output logic [15:0] mode,
  output logic        sci_wr,
  output logic [3:0]  sci_addr,
  output logic [15:0] sci_data,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(SCI_BUSY + 1);

  logic [1:0] xcs_q, xdcs_q, sclk_q, si_q;
  logic       sclk_d;
  logic       xcs_s, xdcs_s, si_s, rise, fall;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      xcs_q  <= 2'b11;
      xdcs_q <= 2'b11;
      sclk_q <= 2'b00;
      si_q   <= 2'b00;
      sclk_d <= 1'b0;
    end else begin
      xcs_q  <= {xcs_q[0], XCS};
      xdcs_q <= {xdcs_q[0], XDCS};
      sclk_q <= {sclk_q[0], SCLK};
      si_q   <= {si_q[0], SI};
      sclk_d <= sclk_q[1];
    end
  end

  assign xcs_s  = xcs_q[1];
  assign xdcs_s = xdcs_q[1];
  assign si_s   = si_q[1];
  assign rise   = sclk_q[1] && !sclk_d;
  assign fall   = !sclk_q[1] && sclk_d;

  sci_state_t  state;
  logic [3:0]  bit_cnt;
  logic [14:0] sr;
  logic        is_read, addr_inv;
  logic [3:0]  addr_q;
  logic [15:0] rd_sr;
  logic [15:0] regs [16];
  logic [7:0]  rx_byte;
  logic [15:0] wr_word;
  logic        wr_fire, soft_rst;

  assign rx_byte  = {sr[6:0], si_s};
  assign wr_word  = {sr, si_s};
  assign wr_fire  = !xcs_s && (state == SCI_DATA) && rise && (bit_cnt == 4'd15)
                    && !is_read && !addr_inv;
  assign soft_rst = wr_fire && (addr_q == ADDR_MODE) && wr_word[SM_RESET];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= SCI_IDLE;
      bit_cnt  <= '0;
      sr       <= '0;
      is_read  <= 1'b0;
      addr_inv <= 1'b0;
      addr_q   <= '0;
      rd_sr    <= '0;
      SO       <= 1'b0;
    end else if (xcs_s) begin
      state   <= SCI_IDLE;
      bit_cnt <= '0;
      SO      <= 1'b0;
    end else begin
      case (state)
        SCI_IDLE: begin
          state   <= SCI_OPCODE;
          bit_cnt <= '0;
        end
        SCI_OPCODE: if (rise) begin
          sr      <= {sr[13:0], si_s};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt <= '0;
            if (rx_byte == OP_WRITE) begin
              is_read <= 1'b0;
              state   <= SCI_ADDR;
            end else if (rx_byte == OP_READ) begin
              is_read <= 1'b1;
              state   <= SCI_ADDR;
            end else begin
              state   <= SCI_IGNORE;
            end
          end
        end
        SCI_ADDR: if (rise) begin
          sr      <= {sr[13:0], si_s};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt  <= '0;
            addr_q   <= rx_byte[3:0];
            addr_inv <= |rx_byte[7:4];
            rd_sr    <= (|rx_byte[7:4]) ? 16'h0000 : regs[rx_byte[3:0]];
            state    <= SCI_DATA;
          end
        end
        SCI_DATA: begin
          // read data leaves on falling edges so it is stable at the next rise
          if (fall && is_read) begin
            SO    <= rd_sr[15];
            rd_sr <= {rd_sr[14:0], 1'b0};
          end
          if (rise) begin
            sr      <= {sr[13:0], si_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state <= SCI_IGNORE;
          end
        end
        SCI_IGNORE: state <= SCI_IGNORE;
        default:    state <= SCI_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) regs[i] <= reg_reset_val(4'(i));
      sci_wr   <= 1'b0;
      sci_addr <= '0;
      sci_data <= '0;
    end else begin
      sci_wr <= wr_fire;
      if (wr_fire) begin
        sci_addr <= addr_q;
        sci_data <= wr_word;
        if (soft_rst) begin
          for (int i = 0; i < 16; i++) regs[i] <= reg_reset_val(4'(i));
        end else begin
          regs[addr_q] <= wr_word;
        end
      end
    end
  end

  assign vol  = regs[ADDR_VOL];
  assign mode = regs[ADDR_MODE];

  // SDI is only listened to while SCI is deselected
  logic       sdi_on, push;
  logic [2:0] sdi_cnt;
  logic [6:0] sdi_sr;
  logic [CW-1:0] fifo_count, free_cnt;
  logic       fifo_full, fifo_empty;

  assign sdi_on = !xdcs_s && xcs_s;
  assign push   = sdi_on && rise && (sdi_cnt == 3'd7);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sdi_cnt <= '0;
      sdi_sr  <= '0;
    end else if (!sdi_on) begin
      sdi_cnt <= '0;
    end else if (rise) begin
      sdi_sr  <= {sdi_sr[5:0], si_s};
      sdi_cnt <= sdi_cnt + 3'd1;
    end
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .flush   (soft_rst),
    .push    (push),
    .wr_data ({sdi_sr, si_s}),
    .pop     (dout_ready),
    .rd_data (dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dout_valid = !fifo_empty;
  assign free_cnt   = CW'(FIFO_DEPTH) - fifo_count;

  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] busy_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow <= 1'b0;
      hold_cnt <= HW'(RESET_CYCLES);
      busy_cnt <= '0;
      DREQ     <= 1'b0;
    end else begin
      if (soft_rst)               overflow <= 1'b0;
      else if (push && fifo_full) overflow <= 1'b1;
      if (soft_rst)               hold_cnt <= HW'(RESET_CYCLES);
      else if (hold_cnt != '0)    hold_cnt <= hold_cnt - HW'(1);
      if (wr_fire)                busy_cnt <= BW'(SCI_BUSY);
      else if (busy_cnt != '0)    busy_cnt <= busy_cnt - BW'(1);
      DREQ <= (hold_cnt == '0) && (busy_cnt == '0) && (free_cnt >= CW'(DREQ_SPACE));
    end
  end

endmodule

// File: tb/tb_vs1003_responder.sv
// Self-checking bench: SCI vector table plus SDI FIFO scoreboard and soft-reset sequence.
module tb_vs1003_responder;

  localparam int FIFO_DEPTH   = 32;
  localparam int DREQ_SPACE   = 4;
  localparam int SCI_BUSY     = 64;
  localparam int RESET_CYCLES = 1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        XCS = 1'b1, XDCS = 1'b1, SCLK = 1'b0, SI = 1'b0;
  logic        SO, DREQ, sci_wr, dout_valid, overflow;
  logic        dout_ready = 1'b0;
  logic [15:0] vol, mode, sci_data;
  logic [3:0]  sci_addr;
  logic [7:0]  dout;

  vs1003_responder #(
    .FIFO_DEPTH(FIFO_DEPTH), .DREQ_SPACE(DREQ_SPACE),
    .SCI_BUSY(SCI_BUSY), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .XCS(XCS), .XDCS(XDCS), .SCLK(SCLK), .SI(SI),
    .SO(SO), .DREQ(DREQ), .vol(vol), .mode(mode), .sci_wr(sci_wr),
    .sci_addr(sci_addr), .sci_data(sci_data), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] q [$];
  int wr_pulses = 0;
  int low_cnt = 0;
  int last_low = -1;
  bit counting = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // sci_wr pulse count and DREQ low length following each committed write
  always @(negedge CLK) begin
    if (sci_wr) begin
      wr_pulses++;
      counting = 1;
      low_cnt  = 0;
    end else if (counting) begin
      if (!DREQ) low_cnt++;
      else begin
        counting = 0;
        last_low = low_cnt;
      end
    end
  end

  // FIFO scoreboard: compare each popped head byte against the queue
  always @(negedge CLK) begin
    if (dout_valid && dout_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_extra: got 0x%0h expected no byte", dout);
      end else begin
        check("fifo_byte", {24'h0, dout}, {24'h0, q.pop_front()});
      end
    end
  end

  task automatic sci_xfer(input logic [31:0] w, input int nbits, output logic [15:0] rd);
    rd = '0;
    @(negedge CLK);
    XCS = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      SI = w[31-i];
      #80;
      if (i >= 16) rd = {rd[14:0], SO};
      SCLK = 1'b1;
      #80 SCLK = 1'b0;
    end
    #80 XCS = 1'b1;
    SI = 1'b0;
    #160;
  endtask

  task automatic sdi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      SI = b[i];
      #80 SCLK = 1'b1;
      #80 SCLK = 1'b0;
    end
  endtask

  task automatic wait_dreq_high(input int budget, input string name);
    int n = 0;
    while (!DREQ && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, {31'h0, DREQ}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] cmd;
    int          nbits;
    bit          is_rd;
    logic [15:0] exp_rd;
    logic [15:0] exp_vol;
    logic [15:0] exp_mode;
    bit          exp_wr;
    logic [3:0]  exp_addr;
  } sci_vec_t;

  sci_vec_t vecs [10];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    int p0, n;
    int mcnt;
    bit exp_ovf;

    vecs[0] = '{32'h020B2020, 32, 1'b0, 16'h0000, 16'h2020, 16'h0800, 1'b1, 4'hB};
    vecs[1] = '{32'h030B0000, 32, 1'b1, 16'h2020, 16'h2020, 16'h0800, 1'b0, 4'h0};
    vecs[2] = '{32'h03200000, 32, 1'b1, 16'h0000, 16'h2020, 16'h0800, 1'b0, 4'h0};
    vecs[3] = '{32'h020BFFFF, 20, 1'b0, 16'h0000, 16'h2020, 16'h0800, 1'b0, 4'h0};
    vecs[4] = '{32'h020B3344, 32, 1'b0, 16'h0000, 16'h3344, 16'h0800, 1'b1, 4'hB};
    vecs[5] = '{32'h02000821, 32, 1'b0, 16'h0000, 16'h3344, 16'h0821, 1'b1, 4'h0};
    vecs[6] = '{32'h03000000, 32, 1'b1, 16'h0821, 16'h3344, 16'h0821, 1'b0, 4'h0};
    vecs[7] = '{32'h050B5555, 32, 1'b0, 16'h0000, 16'h3344, 16'h0821, 1'b0, 4'h0};
    vecs[8] = '{32'h02205555, 32, 1'b0, 16'h0000, 16'h3344, 16'h0821, 1'b0, 4'h0};
    vecs[9] = '{32'h030B0000, 32, 1'b1, 16'h3344, 16'h3344, 16'h0821, 1'b0, 4'h0};

    // reset state
    #50;
    check("rst_dreq", {31'h0, DREQ}, 32'h0);
    check("rst_so", {31'h0, SO}, 32'h0);
    check("rst_vol", {16'h0, vol}, 32'h0);
    check("rst_mode", {16'h0, mode}, 32'h0800);
    check("rst_sci_wr", {31'h0, sci_wr}, 32'h0);
    check("rst_valid", {31'h0, dout_valid}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    n = 0;
    while (n < 2 * RESET_CYCLES) begin
      @(posedge CLK);
      #1;
      n++;
      if (DREQ) break;
    end
    check("rst_dreq_delay", n, RESET_CYCLES + 1);

    // SCI vector table
    for (int v = 0; v < 10; v++) begin
      last_low = -1;
      p0 = wr_pulses;
      sci_xfer(vecs[v].cmd, vecs[v].nbits, rd);
      wait_dreq_high(500, "sci_dreq_recover");
      @(negedge CLK);
      @(negedge CLK);
      check("sci_vol", {16'h0, vol}, {16'h0, vecs[v].exp_vol});
      check("sci_mode", {16'h0, mode}, {16'h0, vecs[v].exp_mode});
      check("sci_wr_count", wr_pulses - p0, vecs[v].exp_wr ? 1 : 0);
      check("sci_busy_len", last_low, vecs[v].exp_wr ? SCI_BUSY : -1);
      if (vecs[v].exp_wr) begin
        check("sci_addr", {28'h0, sci_addr}, {28'h0, vecs[v].exp_addr});
        check("sci_data", {16'h0, sci_data}, {16'h0, vecs[v].cmd[15:0]});
      end
      if (vecs[v].is_rd) begin
        check("sci_read", {16'h0, rd}, {16'h0, vecs[v].exp_rd});
        check("so_idle", {31'h0, SO}, 32'h0);
      end
    end

    // SDI fill past full with no reads
    dout_ready = 1'b0;
    mcnt = 0;
    exp_ovf = 0;
    @(negedge CLK);
    XDCS = 1'b0;
    #80;
    for (int b = 0; b < 40; b++) begin
      if (mcnt < FIFO_DEPTH) begin
        q.push_back(8'(b));
        mcnt++;
      end else begin
        exp_ovf = 1;
      end
      sdi_byte(8'(b));
      @(negedge CLK);
      check("sdi_dreq", {31'h0, DREQ}, (FIFO_DEPTH - mcnt >= DREQ_SPACE) ? 32'h1 : 32'h0);
      check("sdi_overflow", {31'h0, overflow}, {31'h0, exp_ovf});
    end
    XDCS = 1'b1;
    dout_ready = 1'b1;
    for (n = 0; n < 400 && q.size() != 0; n++) @(negedge CLK);
    check("drain_done", q.size(), 0);
    @(negedge CLK);
    @(negedge CLK);
    check("drain_empty", {31'h0, dout_valid}, 32'h0);
    check("drain_dreq", {31'h0, DREQ}, 32'h1);

    // partial SDI byte discarded when XDCS rises
    XDCS = 1'b0;
    #80;
    for (int i = 0; i < 3; i++) begin
      SI = i[0] ? 1'b0 : 1'b1;
      #80 SCLK = 1'b1;
      #80 SCLK = 1'b0;
    end
    #80 XDCS = 1'b1;
    #200;
    q.push_back(8'hA5);
    XDCS = 1'b0;
    #80;
    sdi_byte(8'hA5);
    XDCS = 1'b1;
    for (n = 0; n < 100 && q.size() != 0; n++) @(negedge CLK);
    check("partial_discard", q.size(), 0);
    dout_ready = 1'b0;

    // soft reset with a full FIFO and overflow set
    @(negedge CLK);
    XDCS = 1'b0;
    #80;
    for (int b = 0; b < 40; b++) sdi_byte(8'(b + 8'h40));
    XDCS = 1'b1;
    #200;
    check("pre_soft_valid", {31'h0, dout_valid}, 32'h1);
    check("pre_soft_ovf", {31'h0, overflow}, 32'h1);
    last_low = -1;
    p0 = wr_pulses;
    sci_xfer(32'h02000804, 32, rd);
    wait_dreq_high(3 * RESET_CYCLES, "soft_dreq_recover");
    @(negedge CLK);
    @(negedge CLK);
    check("soft_mode", {16'h0, mode}, 32'h0800);
    check("soft_vol", {16'h0, vol}, 32'h0);
    check("soft_valid", {31'h0, dout_valid}, 32'h0);
    check("soft_ovf", {31'h0, overflow}, 32'h0);
    check("soft_wr_count", wr_pulses - p0, 1);
    check("soft_addr", {28'h0, sci_addr}, 32'h0);
    check("soft_data", {16'h0, sci_data}, 32'h0804);
    check("soft_hold_len", last_low, RESET_CYCLES);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
